// File: rtl/snn_debug_pkg.sv
// Shared constants, FSM state type and frame-length helper for the SNN debug readout.
package snn_debug_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // header + seq + padded spike bytes + one byte per neuron + checksum
    function automatic int frame_len(input int n1, input int n2);
        return 2 + (n1 + 7) / 8 + (n2 + 7) / 8 + (n1 + n2) + 1;
    endfunction

endpackage

// File: rtl/snn_debug_readout_if.sv
// Byte-stream valid/ready link from the debug readout toward the host bridge.
interface snn_debug_readout_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/snn_frame_byte_sel.sv
// Picks the frame byte at position idx from the captured snapshot, seq and checksum.
module snn_frame_byte_sel
    import snn_debug_pkg::*;
#(
    parameter int N1   = 8,
    parameter int N2   = 2,
    parameter int MP_W = 6,
    parameter int K    = frame_len(N1, N2),
    parameter int IDX_W = $clog2(K)
) (
    input  logic [(N1+N2)*MP_W-1:0] snap_mp,
    input  logic [N1-1:0]           snap_l1,
    input  logic [N2-1:0]           snap_l2,
    input  logic [7:0]              seq,
    input  logic [7:0]              crc,
    input  logic [IDX_W-1:0]        idx,
    output logic [7:0]              byte_out
);
    localparam int L1B     = (N1 + 7) / 8;
    localparam int L2B     = (N2 + 7) / 8;
    localparam int MP_BASE = 2 + L1B + L2B;

    logic [L1B*8-1:0] l1_pad;
    logic [L2B*8-1:0] l2_pad;

    // Byte mux; spike vectors are zero-padded up to whole bytes, MPs zero-extended.
    always_comb begin
        byte_out = 8'h00;
        l1_pad = '0;
        l1_pad[N1-1:0] = snap_l1;
        l2_pad = '0;
        l2_pad[N2-1:0] = snap_l2;
        if (int'(idx) == 0) begin
            byte_out = HDR_BYTE;
        end else if (int'(idx) == 1) begin
            byte_out = seq;
        end else if (int'(idx) == K - 1) begin
            byte_out = crc;
        end else begin
            for (int b = 0; b < L1B; b++)
                if (int'(idx) == 2 + b) byte_out = l1_pad[b*8 +: 8];
            for (int b = 0; b < L2B; b++)
                if (int'(idx) == 2 + L1B + b) byte_out = l2_pad[b*8 +: 8];
            for (int n = 0; n < N1 + N2; n++)
                if (int'(idx) == MP_BASE + n) begin
                    byte_out = 8'h00;
                    byte_out[MP_W-1:0] = snap_mp[n*MP_W +: MP_W];
                end
        end
    end

endmodule

// File: rtl/snn_debug_readout.sv
// SNN debug readout: snapshots membrane potentials and spikes on capture and
// streams them as a checksummed byte frame over a valid/ready link.
//
//   state | meaning
//   IDLE  | waiting for capture && enable; link idle
//   SEND  | frame in flight; byte idx presented until handshake
module snn_debug_readout
    import snn_debug_pkg::*;
#(
    parameter int N1   = 8,
    parameter int N2   = 2,
    parameter int MP_W = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    capture,
    input  logic [(N1+N2)*MP_W-1:0] membrane_potential_in,
    input  logic [N1-1:0]           spikes_layer1_in,
    input  logic [N2-1:0]           spikes_out_in,
    input  logic                    clear_overrun,
    snn_debug_readout_if.master     tx,
    output logic                    busy,
    output logic                    overrun
);
    localparam int K     = frame_len(N1, N2);
    localparam int IDX_W = $clog2(K);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        idx;
    logic [7:0]              seq;
    logic [7:0]              crc;
    logic [7:0]              sel_byte;
    logic [(N1+N2)*MP_W-1:0] snap_mp;
    logic [N1-1:0]           snap_l1;
    logic [N2-1:0]           snap_l2;
    logic                    start;
    logic                    hs;
    logic                    done;
    logic                    last_byte;

    snn_frame_byte_sel #(.N1(N1), .N2(N2), .MP_W(MP_W), .K(K), .IDX_W(IDX_W)) u_byte_sel (
        .snap_mp  (snap_mp),
        .snap_l1  (snap_l1),
        .snap_l2  (snap_l2),
        .seq      (seq),
        .crc      (crc),
        .idx      (idx),
        .byte_out (sel_byte)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and link outputs; tx_data held at zero outside a frame.
    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        hs          = 1'b0;
        done        = 1'b0;
        busy        = 1'b0;
        last_byte   = (idx == LAST_IDX);
        tx.tx_valid = 1'b0;
        tx.tx_last  = 1'b0;
        tx.tx_data  = 8'h00;
        case (state)
            IDLE: begin
                if (capture && enable) begin
                    start     = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                busy        = 1'b1;
                tx.tx_valid = 1'b1;
                tx.tx_data  = sel_byte;
                tx.tx_last  = last_byte;
                hs          = tx.tx_ready;
                if (hs && last_byte) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot of the network inputs, taken only when a frame is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_mp <= '0;
            snap_l1 <= '0;
            snap_l2 <= '0;
        end else if (start) begin
            snap_mp <= membrane_potential_in;
            snap_l1 <= spikes_layer1_in;
            snap_l2 <= spikes_out_in;
        end
    end

    // Byte index and running XOR of accepted bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
            crc <= 8'h00;
        end else if (start) begin
            idx <= '0;
            crc <= 8'h00;
        end else if (hs) begin
            idx <= done ? '0 : idx + 1'b1;
            crc <= crc ^ sel_byte;
        end
    end

    // Frame sequence number, bumped once per completed frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     seq <= 8'h00;
        else if (done) seq <= seq + 8'h01;
    end

    // Sticky overrun; a dropped capture beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        overrun <= 1'b0;
        else if (capture && state == SEND) overrun <= 1'b1;
        else if (clear_overrun)           overrun <= 1'b0;
    end

endmodule

// File: tb/tb_snn_debug_readout.sv
// Bench for snn_debug_readout: frame-level model checked every negedge plus
// hand-computed literal frames for the directed cases.
module tb_snn_debug_readout;
    localparam int N1 = 8;
    localparam int N2 = 2;
    localparam int MP_W = 6;
    localparam int K = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        capture = 1'b0;
    logic [59:0] mp = '0;
    logic [7:0]  spk1 = '0;
    logic [1:0]  spk2 = '0;
    logic        clear_overrun = 1'b0;
    logic        busy;
    logic        overrun;

    int n_tests = 0;
    int n_fail = 0;

    snn_debug_readout_if tx_if ();

    snn_debug_readout #(.N1(N1), .N2(N2), .MP_W(MP_W)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .enable                (enable),
        .capture               (capture),
        .membrane_potential_in (mp),
        .spikes_layer1_in      (spk1),
        .spikes_out_in         (spk2),
        .clear_overrun         (clear_overrun),
        .tx                    (tx_if),
        .busy                  (busy),
        .overrun               (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: a frame is a list of bytes built from the inputs at capture.
    logic       m_busy = 1'b0;
    logic [7:0] m_seq = 8'h00;
    logic       m_ovr = 1'b0;
    int         m_idx = 0;
    logic [7:0] m_frame [K];
    logic [7:0] rx_q [$];
    logic       rx_last [$];

    always @(negedge clk) begin
        logic [7:0] x;
        if (reset) begin
            chk("rst_valid", {31'b0, tx_if.tx_valid}, 0);
            chk("rst_busy", {31'b0, busy}, 0);
            chk("rst_last", {31'b0, tx_if.tx_last}, 0);
            chk("rst_data", {24'b0, tx_if.tx_data}, 0);
            chk("rst_ovr", {31'b0, overrun}, 0);
            m_busy = 1'b0;
            m_seq = 8'h00;
            m_ovr = 1'b0;
            m_idx = 0;
        end else begin
            chk("valid", {31'b0, tx_if.tx_valid}, {31'b0, m_busy});
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("overrun", {31'b0, overrun}, {31'b0, m_ovr});
            chk("data", {24'b0, tx_if.tx_data}, m_busy ? {24'b0, m_frame[m_idx]} : 32'h0);
            chk("last", {31'b0, tx_if.tx_last}, {31'b0, (m_busy && m_idx == K - 1)});
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                rx_q.push_back(tx_if.tx_data);
                rx_last.push_back(tx_if.tx_last);
            end
            if (m_busy) begin
                if (capture) m_ovr = 1'b1;
                else if (clear_overrun) m_ovr = 1'b0;
                if (tx_if.tx_ready) begin
                    m_idx++;
                    if (m_idx == K) begin
                        m_busy = 1'b0;
                        m_idx = 0;
                        m_seq = m_seq + 8'h01;
                    end
                end
            end else begin
                if (clear_overrun) m_ovr = 1'b0;
                if (capture && enable) begin
                    m_frame[0] = 8'hA5;
                    m_frame[1] = m_seq;
                    m_frame[2] = spk1;
                    m_frame[3] = {6'b0, spk2};
                    for (int n = 0; n < N1 + N2; n++) m_frame[4 + n] = {2'b0, mp[n*MP_W +: MP_W]};
                    x = 8'h00;
                    for (int i = 0; i < K - 1; i++) x = x ^ m_frame[i];
                    m_frame[K - 1] = x;
                    m_busy = 1'b1;
                    m_idx = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mp(input logic [5:0] v);
        for (int n = 0; n < N1 + N2; n++) mp[n*MP_W +: MP_W] = v;
    endtask

    task automatic pulse_capture();
        capture = 1'b1;
        tick();
        capture = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (busy && i < budget) begin
            tick();
            i++;
        end
        chk("idle_timeout", {31'b0, busy}, 0);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int i = 0;
        while (rx_q.size() < n && i < budget) begin
            tick();
            i++;
        end
        chk("rx_timeout", rx_q.size(), n);
    endtask

    // Frame with MP=0A, L1=FF, L2=01 and the given seq/checksum.
    task automatic check_frame(input string name, input logic [7:0] seqv, input logic [7:0] crcv);
        logic [7:0] e;
        chk({name, "_len"}, rx_q.size(), K);
        if (rx_q.size() == K) begin
            for (int i = 0; i < K; i++) begin
                if (i == 0) e = 8'hA5;
                else if (i == 1) e = seqv;
                else if (i == 2) e = 8'hFF;
                else if (i == 3) e = 8'h01;
                else if (i == K - 1) e = crcv;
                else e = 8'h0A;
                chk($sformatf("%s_b%0d", name, i), {24'b0, rx_q[i]}, {24'b0, e});
                chk($sformatf("%s_l%0d", name, i), {31'b0, rx_last[i]}, {31'b0, (i == K - 1)});
            end
        end
    endtask

    task automatic run_frame();
        rx_q.delete();
        rx_last.delete();
        pulse_capture();
        wait_idle(200);
    endtask

    initial begin
        tx_if.tx_ready = 1'b1;
        set_mp(6'h0A);
        spk1 = 8'hFF;
        spk2 = 2'b01;
        tick();
        tick();
        chk("reset_valid", {31'b0, tx_if.tx_valid}, 0);
        reset = 1'b0;
        tick();
        chk("post_reset_busy", {31'b0, busy}, 0);
        chk("post_reset_data", {24'b0, tx_if.tx_data}, 0);

        // 1: basic frame
        run_frame();
        check_frame("basic", 8'h00, 8'h5B);

        // 2: seq increments and wraps
        run_frame();
        check_frame("seq1", 8'h01, 8'h5A);
        for (int f = 2; f < 256; f++) run_frame();
        check_frame("seqFF", 8'hFF, 8'hA4);
        run_frame();
        check_frame("seq_wrap", 8'h00, 8'h5B);

        // 3: backpressure on byte 5, then random ready
        rx_q.delete();
        rx_last.delete();
        pulse_capture();
        wait_rx(5, 50);
        tx_if.tx_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("stall_data", {24'b0, tx_if.tx_data}, 32'h0A);
            chk("stall_valid", {31'b0, tx_if.tx_valid}, 1);
            tick();
        end
        tx_if.tx_ready = 1'b1;
        wait_idle(100);
        check_frame("stall", 8'h01, 8'h5A);

        rx_q.delete();
        rx_last.delete();
        pulse_capture();
        for (int i = 0; i < 500 && busy; i++) begin
            tx_if.tx_ready = 1'($urandom_range(0, 1));
            tick();
        end
        tx_if.tx_ready = 1'b1;
        wait_idle(100);
        check_frame("rand_ready", 8'h02, 8'h59);

        // 4: overrun, mid-frame input change, clear behaviour
        rx_q.delete();
        rx_last.delete();
        pulse_capture();
        wait_rx(7, 50);
        set_mp(6'h3F);
        pulse_capture();
        chk("overrun_set", {31'b0, overrun}, 1);
        wait_idle(100);
        check_frame("overrun_frame", 8'h03, 8'h58);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk("overrun_clr", {31'b0, overrun}, 0);
        rx_q.delete();
        rx_last.delete();
        pulse_capture();
        tick();
        capture = 1'b1;
        clear_overrun = 1'b1;
        tick();
        capture = 1'b0;
        clear_overrun = 1'b0;
        chk("set_wins", {31'b0, overrun}, 1);
        wait_idle(100);
        chk("mp3f_b4", {24'b0, rx_q[4]}, 32'h3F);
        chk("mp3f_crc", {24'b0, rx_q[K - 1]}, 32'h5F);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        set_mp(6'h0A);

        // 5: enable gating
        enable = 1'b0;
        pulse_capture();
        tick();
        tick();
        chk("dis_valid", {31'b0, tx_if.tx_valid}, 0);
        chk("dis_ovr", {31'b0, overrun}, 0);
        enable = 1'b1;
        rx_q.delete();
        rx_last.delete();
        pulse_capture();
        tick();
        tick();
        enable = 1'b0;
        wait_idle(100);
        check_frame("en_drop", 8'h05, 8'h5E);
        enable = 1'b1;

        // 6: reset mid-frame
        rx_q.delete();
        rx_last.delete();
        pulse_capture();
        wait_rx(7, 50);
        reset = 1'b1;
        #1;
        chk("arst_valid", {31'b0, tx_if.tx_valid}, 0);
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_last", {31'b0, tx_if.tx_last}, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        run_frame();
        check_frame("after_rst", 8'h00, 8'h5B);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
